// File: rtl/reg_scoreboard_pkg.sv
// reg_scoreboard_pkg: forwarding bus layouts and widths shared by the hazard controller.
package reg_scoreboard_pkg;
   localparam int ES_FWD_BUS_WD   = 39;
   localparam int MS_FWD_BUS_WD   = 38;
   localparam int WS_TO_ID_BUS_WD = 38;
   typedef struct packed {
      logic        load;
      logic        wen;
      logic [4:0]  dest;
      logic [31:0] value;
   } es_fwd_t;
   typedef struct packed {
      logic        wen;
      logic [4:0]  dest;
      logic [31:0] value;
   } fwd_t;
endpackage

// File: rtl/reg_scoreboard_fwd_sel.sv
// fwd_sel: priority bypass match (EX > MEM > WB > register file) for one source operand.
module fwd_sel
   import reg_scoreboard_pkg::*;
(
   input  logic [4:0]  src,
   input  logic        ren,
   input  es_fwd_t     es,
   input  fwd_t        ms,
   input  fwd_t        ws,
   input  logic [31:0] rf_value,
   output logic [31:0] value,
   output logic        hit,
   output logic        load_hit
);
   logic live, es_hit, ms_hit, ws_hit;
   assign live     = ren && src != 5'd0;
   assign es_hit   = live && es.wen && es.dest == src;
   assign ms_hit   = live && ms.wen && ms.dest == src;
   assign ws_hit   = live && ws.wen && ws.dest == src;
   assign hit      = es_hit || ms_hit || ws_hit;
   assign load_hit = es_hit && es.load;
   assign value    = src == 5'd0 ? 32'd0 :
                     es_hit      ? es.value :
                     ms_hit      ? ms.value :
                     ws_hit      ? ws.value : rf_value;
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: per-GPR in-flight writer counters, operand bypass and ID stall generation.
module reg_scoreboard
   import reg_scoreboard_pkg::*;
#(
   parameter int NREG  = 32,
   parameter int CNT_W = 2
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       ds_valid,
   input  logic [4:0]                 ds_rs,
   input  logic [4:0]                 ds_rt,
   input  logic                       ds_rs_ren,
   input  logic                       ds_rt_ren,
   input  logic [4:0]                 ds_dest,
   input  logic                       ds_gr_we,
   input  logic                       ds_issue,
   input  logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus,
   input  logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus,
   input  logic [WS_TO_ID_BUS_WD-1:0] ws_to_id_bus,
   output logic                       ds_ready_go,
   input  logic [31:0]                rs_value,
   input  logic [31:0]                rt_value,
   output logic [31:0]                rs_fwd,
   output logic [31:0]                rt_fwd,
   output logic                       sb_err
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   es_fwd_t es;
   fwd_t ms, ws;
   logic [NREG-1:0][CNT_W-1:0] cnt;
   logic rs_hit, rt_hit, rs_ld, rt_ld, stall_a, stall_b, stall_c, retire;
   assign es = es_fwd_bus;
   assign ms = ms_fwd_bus;
   assign ws = ws_to_id_bus;
   assign retire = ws.wen && ws.dest != 5'd0;
   fwd_sel u_rs (.src(ds_rs), .ren(ds_rs_ren), .es(es), .ms(ms), .ws(ws), .rf_value(rs_value),
                 .value(rs_fwd), .hit(rs_hit), .load_hit(rs_ld));
   fwd_sel u_rt (.src(ds_rt), .ren(ds_rt_ren), .es(es), .ms(ms), .ws(ws), .rf_value(rt_value),
                 .value(rt_fwd), .hit(rt_hit), .load_hit(rt_ld));
   assign stall_a = rs_ld || rt_ld;
   // An in-flight writer with no bus carrying it yet (bubble gap) must wait.
   assign stall_b = (ds_rs_ren && ds_rs != 5'd0 && cnt[ds_rs] != '0 && !rs_hit) ||
                    (ds_rt_ren && ds_rt != 5'd0 && cnt[ds_rt] != '0 && !rt_hit);
   assign stall_c = ds_valid && ds_gr_we && ds_dest != 5'd0 && cnt[ds_dest] == CNT_MAX &&
                    !(ws.wen && ws.dest == ds_dest);
   assign ds_ready_go = !(stall_a || stall_b || stall_c);
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt    <= '0;
         sb_err <= 1'b0;
      end else begin
         for (int r = 1; r < NREG; r++) begin
            if (ds_issue && ds_gr_we && ds_dest == 5'(r) && !(ws.wen && ws.dest == 5'(r)))
               cnt[r] <= cnt[r] + 1'b1;
            else if (ws.wen && ws.dest == 5'(r) && !(ds_issue && ds_gr_we && ds_dest == 5'(r)) && cnt[r] != '0)
               cnt[r] <= cnt[r] - 1'b1;
         end
         if (retire && cnt[ws.dest] == '0)
            sb_err <= 1'b1;
      end
   end
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: scenario tasks with a queue of expected results checked against the DUT.
module tb_reg_scoreboard;
   logic clk = 1'b0, reset;
   logic ds_valid, ds_rs_ren, ds_rt_ren, ds_gr_we, ds_issue;
   logic [4:0] ds_rs, ds_rt, ds_dest;
   logic [38:0] es_fwd_bus;
   logic [37:0] ms_fwd_bus, ws_to_id_bus;
   logic [31:0] rs_value, rt_value, rs_fwd, rt_fwd;
   logic ds_ready_go, sb_err;
   logic [31:0] exp_q[$];
   logic [31:0] e;
   int checks = 0, failures = 0;

   reg_scoreboard dut (
      .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_rs(ds_rs), .ds_rt(ds_rt),
      .ds_rs_ren(ds_rs_ren), .ds_rt_ren(ds_rt_ren), .ds_dest(ds_dest), .ds_gr_we(ds_gr_we),
      .ds_issue(ds_issue), .es_fwd_bus(es_fwd_bus), .ms_fwd_bus(ms_fwd_bus),
      .ws_to_id_bus(ws_to_id_bus), .ds_ready_go(ds_ready_go), .rs_value(rs_value),
      .rt_value(rt_value), .rs_fwd(rs_fwd), .rt_fwd(rt_fwd), .sb_err(sb_err)
   );

   always #5 clk = ~clk;

   function automatic logic [38:0] esb(input logic l, input logic w, input logic [4:0] d, input logic [31:0] v);
      return {l, w, d, v};
   endfunction
   function automatic logic [37:0] fb(input logic w, input logic [4:0] d, input logic [31:0] v);
      return {w, d, v};
   endfunction

   task automatic idle();
      reset = 1'b0; ds_valid = 1'b0; ds_rs = '0; ds_rt = '0; ds_rs_ren = 1'b0; ds_rt_ren = 1'b0;
      ds_dest = '0; ds_gr_we = 1'b0; ds_issue = 1'b0; es_fwd_bus = '0; ms_fwd_bus = '0;
      ws_to_id_bus = '0; rs_value = 32'hdead_0001; rt_value = 32'hdead_0002;
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic issue(input logic [4:0] d);
      idle();
      ds_valid = 1'b1; ds_dest = d; ds_gr_we = 1'b1; ds_issue = 1'b1;
      step();
      idle();
   endtask

   task automatic test_reset();
      idle();
      reset = 1'b1;
      step(); step();
      idle();
      ds_valid = 1'b1; ds_rs = 5'd5; ds_rs_ren = 1'b1; rs_value = 32'hcafe_f00d;
      exp_q.push_back(32'd1); exp_q.push_back(32'hcafe_f00d); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ds_ready_go} !== e) begin failures++; $display("FAIL reset_ready ready_go=%0d exp=%0d", ds_ready_go, e); end
      e = exp_q.pop_front(); checks++;
      if (rs_fwd !== e) begin failures++; $display("FAIL reset_rs_fwd got=%h exp=%h", rs_fwd, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, |dut.cnt} !== e) begin failures++; $display("FAIL reset_cnt any_nonzero=%0d exp=%0d", |dut.cnt, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, sb_err} !== e) begin failures++; $display("FAIL reset_sb_err got=%0d exp=%0d", sb_err, e); end
   endtask

   task automatic test_forward();
      issue(5'd8);
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); checks++;
      if ({30'd0, dut.cnt[8]} !== e) begin failures++; $display("FAIL fwd_cnt8 got=%0d exp=%0d", dut.cnt[8], e); end
      ds_valid = 1'b1; ds_rt = 5'd8; ds_rt_ren = 1'b1; es_fwd_bus = esb(1'b0, 1'b1, 5'd8, 32'h11);
      exp_q.push_back(32'h11); exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rt_fwd !== e) begin failures++; $display("FAIL fwd_ex rt_fwd=%h exp=%h", rt_fwd, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ds_ready_go} !== e) begin failures++; $display("FAIL fwd_ex_ready got=%0d exp=%0d", ds_ready_go, e); end
      es_fwd_bus = esb(1'b0, 1'b1, 5'd8, 32'h22); ms_fwd_bus = fb(1'b1, 5'd8, 32'h11);
      exp_q.push_back(32'h22);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rt_fwd !== e) begin failures++; $display("FAIL fwd_ex_over_ms rt_fwd=%h exp=%h", rt_fwd, e); end
      es_fwd_bus = '0; ms_fwd_bus = fb(1'b1, 5'd8, 32'h33); ws_to_id_bus = fb(1'b1, 5'd8, 32'h44);
      exp_q.push_back(32'h33);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rt_fwd !== e) begin failures++; $display("FAIL fwd_ms_over_ws rt_fwd=%h exp=%h", rt_fwd, e); end
      ms_fwd_bus = '0;
      exp_q.push_back(32'h44);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rt_fwd !== e) begin failures++; $display("FAIL fwd_ws rt_fwd=%h exp=%h", rt_fwd, e); end
      step();
      idle();
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); checks++;
      if ({30'd0, dut.cnt[8]} !== e) begin failures++; $display("FAIL fwd_retire_cnt8 got=%0d exp=%0d", dut.cnt[8], e); end
   endtask

   task automatic test_load_use();
      issue(5'd9);
      ds_valid = 1'b1; ds_rs = 5'd9; ds_rs_ren = 1'b1;
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ds_ready_go} !== e) begin failures++; $display("FAIL bubble_gap ready_go=%0d exp=%0d", ds_ready_go, e); end
      es_fwd_bus = esb(1'b1, 1'b1, 5'd9, 32'hbad0);
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ds_ready_go} !== e) begin failures++; $display("FAIL load_use ready_go=%0d exp=%0d", ds_ready_go, e); end
      step();
      es_fwd_bus = '0; ms_fwd_bus = fb(1'b1, 5'd9, 32'h1234);
      exp_q.push_back(32'h1234); exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rs_fwd !== e) begin failures++; $display("FAIL load_ms rs_fwd=%h exp=%h", rs_fwd, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ds_ready_go} !== e) begin failures++; $display("FAIL load_ms_ready got=%0d exp=%0d", ds_ready_go, e); end
      ds_rs_ren = 1'b0; ms_fwd_bus = '0; es_fwd_bus = esb(1'b1, 1'b1, 5'd9, 32'hbad1);
      exp_q.push_back(32'd1); exp_q.push_back(32'hdead_0001);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ds_ready_go} !== e) begin failures++; $display("FAIL unread_ready got=%0d exp=%0d", ds_ready_go, e); end
      e = exp_q.pop_front(); checks++;
      if (rs_fwd !== e) begin failures++; $display("FAIL unread_fwd rs_fwd=%h exp=%h", rs_fwd, e); end
      idle();
      ws_to_id_bus = fb(1'b1, 5'd9, 32'h1234);
      step();
      idle();
   endtask

   task automatic test_saturate();
      issue(5'd3); issue(5'd3); issue(5'd3);
      exp_q.push_back(32'd3);
      e = exp_q.pop_front(); checks++;
      if ({30'd0, dut.cnt[3]} !== e) begin failures++; $display("FAIL sat_cnt3 got=%0d exp=%0d", dut.cnt[3], e); end
      ds_valid = 1'b1; ds_dest = 5'd3; ds_gr_we = 1'b1;
      exp_q.push_back(32'd0);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ds_ready_go} !== e) begin failures++; $display("FAIL sat_stall ready_go=%0d exp=%0d", ds_ready_go, e); end
      ws_to_id_bus = fb(1'b1, 5'd3, 32'h3);
      exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ds_ready_go} !== e) begin failures++; $display("FAIL sat_retire_ready got=%0d exp=%0d", ds_ready_go, e); end
      ds_issue = 1'b1;
      step();
      idle();
      exp_q.push_back(32'd3);
      e = exp_q.pop_front(); checks++;
      if ({30'd0, dut.cnt[3]} !== e) begin failures++; $display("FAIL sat_hold_cnt3 got=%0d exp=%0d", dut.cnt[3], e); end
      for (int i = 0; i < 3; i++) begin
         ws_to_id_bus = fb(1'b1, 5'd3, 32'h3);
         step();
      end
      idle();
      exp_q.push_back(32'd0);
      e = exp_q.pop_front(); checks++;
      if ({30'd0, dut.cnt[3]} !== e) begin failures++; $display("FAIL sat_drain_cnt3 got=%0d exp=%0d", dut.cnt[3], e); end
   endtask

   task automatic test_back_to_back();
      issue(5'd4);
      ds_valid = 1'b1; ds_dest = 5'd4; ds_gr_we = 1'b1; ds_issue = 1'b1;
      ws_to_id_bus = fb(1'b1, 5'd4, 32'h4);
      step();
      idle();
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); checks++;
      if ({30'd0, dut.cnt[4]} !== e) begin failures++; $display("FAIL same_cycle_cnt4 got=%0d exp=%0d", dut.cnt[4], e); end
      ws_to_id_bus = fb(1'b1, 5'd4, 32'h4);
      step();
      idle();
      exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      e = exp_q.pop_front(); checks++;
      if ({30'd0, dut.cnt[4]} !== e) begin failures++; $display("FAIL b2b_drain_cnt4 got=%0d exp=%0d", dut.cnt[4], e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, sb_err} !== e) begin failures++; $display("FAIL b2b_no_err got=%0d exp=%0d", sb_err, e); end
   endtask

   task automatic test_sb_err_zero();
      ws_to_id_bus = fb(1'b1, 5'd6, 32'h6);
      step();
      idle();
      exp_q.push_back(32'd1); exp_q.push_back(32'd0);
      e = exp_q.pop_front(); checks++;
      if ({31'd0, sb_err} !== e) begin failures++; $display("FAIL sb_err_set got=%0d exp=%0d", sb_err, e); end
      e = exp_q.pop_front(); checks++;
      if ({30'd0, dut.cnt[6]} !== e) begin failures++; $display("FAIL sb_err_cnt6 got=%0d exp=%0d", dut.cnt[6], e); end
      step(); step();
      exp_q.push_back(32'd1);
      e = exp_q.pop_front(); checks++;
      if ({31'd0, sb_err} !== e) begin failures++; $display("FAIL sb_err_sticky got=%0d exp=%0d", sb_err, e); end
      ds_valid = 1'b1; ds_rs = 5'd0; ds_rs_ren = 1'b1; rs_value = 32'h5555;
      es_fwd_bus = esb(1'b1, 1'b1, 5'd0, 32'hffff_ffff);
      exp_q.push_back(32'd0); exp_q.push_back(32'd1);
      #1;
      e = exp_q.pop_front(); checks++;
      if (rs_fwd !== e) begin failures++; $display("FAIL zero_reg rs_fwd=%h exp=%h", rs_fwd, e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, ds_ready_go} !== e) begin failures++; $display("FAIL zero_reg_ready got=%0d exp=%0d", ds_ready_go, e); end
      idle();
   endtask

   task automatic test_mid_reset();
      issue(5'd7);
      ds_valid = 1'b1; ds_dest = 5'd5; ds_gr_we = 1'b1; ds_issue = 1'b1; reset = 1'b1;
      ws_to_id_bus = fb(1'b1, 5'd10, 32'h0);
      step();
      idle();
      exp_q.push_back(32'd0); exp_q.push_back(32'd0); exp_q.push_back(32'd0);
      e = exp_q.pop_front(); checks++;
      if ({30'd0, dut.cnt[5]} !== e) begin failures++; $display("FAIL midrst_cnt5 got=%0d exp=%0d", dut.cnt[5], e); end
      e = exp_q.pop_front(); checks++;
      if ({30'd0, dut.cnt[7]} !== e) begin failures++; $display("FAIL midrst_cnt7 got=%0d exp=%0d", dut.cnt[7], e); end
      e = exp_q.pop_front(); checks++;
      if ({31'd0, sb_err} !== e) begin failures++; $display("FAIL midrst_sb_err got=%0d exp=%0d", sb_err, e); end
   endtask

   initial begin
      idle();
      @(negedge clk);
      test_reset();
      test_forward();
      test_load_use();
      test_saturate();
      test_back_to_back();
      test_sb_err_zero();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-hazard controller for the five-stage pipeline. It sits beside the ID stage and tracks how many in-flight instructions will write each GPR: counts go up on issue from ID and down on retire at WB. It selects bypass data from the EX, MEM and WB forwarding buses, and it drops ID's ready-go on an unresolvable RAW hazard or a counter overflow.

## Interface
Parameters:
- `NREG`, 32: number of GPRs; index 0 is hardwired zero.
- `CNT_W`, 2: width of each in-flight counter; maximum count is 2^CNT_W−1.

Ports:
- `clk`  in  1: single clock.
- `reset`  in  1: synchronous, active-high.
- `ds_valid`  in  1: ID holds a valid instruction.
- `ds_rs`, `ds_rt`  in  5 each: source register numbers.
- `ds_rs_ren`, `ds_rt_ren`  in  1 each: source actually read.
- `ds_dest`  in  5: destination register.
- `ds_gr_we`  in  1: instruction writes the GPR file.
- `ds_issue`  in  1: ID→EX transfer this cycle. ID drives it as `ds_valid && ds_ready_go && es_allowin`.
- `es_fwd_bus`  in  39: {es_load, es_wen, es_dest[4:0], es_value[31:0]}. `es_wen` is already qualified by `es_valid`.
- `ms_fwd_bus`  in  38: {ms_wen, ms_dest, ms_value}. Load data is final in MS.
- `ws_to_id_bus`  in  38: {ws_rf_wen, ws_dest, ws_final_result}. This is also the retire event.
- `ds_ready_go`  out  1: ID may advance.
- `rs_value`, `rt_value`  in  32 each: register-file read data.
- `rs_fwd`, `rt_fwd`  out  32 each: operand after bypass.
- `sb_err`  out  1: sticky; set on retire to a register whose count is 0.

## Operation
Per-register counter `cnt[r]`, CNT_W bits, for r=1..NREG−1. `cnt[0]` is constant 0.

Counter update:
- Increment `cnt[ds_dest]` when `ds_issue && ds_gr_we && ds_dest!=0`.
- Decrement `cnt[ws_dest]` when `ws_rf_wen && ws_dest!=0`.
- Increment and decrement on the same register in the same cycle leave it unchanged.
- Decrement with `cnt==0` leaves it at 0 and sets `sb_err`. `sb_err` clears only on reset.

Bypass, per source s ∈ {rs, rt}:
- s==0: value is 0; never stalls.
- Otherwise the first match wins, in priority order:
  1. `es_wen && es_dest==s` → `es_value`.
  2. `ms_wen && ms_dest==s` → `ms_value`.
  3. `ws_rf_wen && ws_dest==s` → `ws_final_result`.
  4. Else → the register-file value.

Stall conditions. `ds_ready_go` = !(A || B || C), where:
- A: a read source matches EX and `es_load` is set (load-use).
- B: a read source has `cnt[s]!=0` but no bus matches. This is an in-flight writer not yet visible, e.g. a bubble gap. It is a safe fallback.
- C: `ds_valid && ds_gr_we && ds_dest!=0 && cnt[ds_dest]==max && !(ws_rf_wen && ws_dest==ds_dest)`. This prevents counter wrap.

Unread sources (`ren`=0) never stall and never forward.

## Timing
- Reset: every `cnt` = 0 and `sb_err` = 0. Because `ds_ready_go` is combinational, it reads 1 when there is no hazard.
- `ds_ready_go`, `rs_fwd` and `rt_fwd` are purely combinational from the current inputs and counters. They have zero-cycle latency.
- Counters update on the `posedge clk` after the issue or retire event and are visible to the next cycle's ID instruction.
- The load-use stall lasts exactly 1 cycle: the next cycle the load is in MS and is forwarded from `ms_value`.
- A retire in cycle t frees a saturated counter combinationally in t (condition C excludes it).
- Reset asserted mid-stream clears all counters on the next edge regardless of in-flight events. No event from the reset cycle is counted.

## Structure
- The `mycpu.h` shared header gains `ES_FWD_BUS_WD` (39) and `MS_FWD_BUS_WD` (38). It reuses the existing 38-bit `ws_to_id_bus` layout.
- One natural sub-module, `fwd_sel`: the combinational 3-bus priority match for a single source, instantiated twice. Its outputs are value, hit and load-hit.
- The counter array and stall logic stay in `reg_scoreboard`.

## Test plan
- Reset, then `ds_valid`=1 reading rs=5 with no traffic → `ds_ready_go`=1, `rs_fwd`=`rs_value`, all counters 0.
- Issue `addu $8` (cnt[8]→1). Next cycle EX bus {0,1,8,0x11}, ID reads rt=8 → `rt_fwd`=0x11, `ready_go`=1. EX and MS both writing $8 (0x22 in EX, 0x11 in MS) → EX value 0x22 wins.
- `lw $9` in EX (es_load=1), ID reads rs=9 → `ready_go`=0 for one cycle. The next cycle MS bus gives 0x1234 → `rs_fwd`=0x1234, `ready_go`=1.
- Three issues to $3 without a retire → cnt[3]=3 and the fourth stalls. Same cycle `ws_rf_wen` to $3 → no stall, and cnt stays 3.
- Simultaneous issue and retire on $4 with cnt=1 → cnt[4] remains 1.
- Retire to $6 with cnt 0 → `sb_err`=1 and stays 1 until reset. Reads of $0 with EX writing $0 → value 0, no stall.
